rx_word_align_ctrl: RTL and testbench

Receive-side word-alignment and link-synchronisation controller. It sits between the deserializer and the 8b/10b decoder. It searches the raw 10-bit parallel stream for the comma sequence and locks a 0–9 bit alignment offset, then presents realigned code-groups to the decoder. It also runs a sync-acquire / loss-of-sync state machine with error hysteresis, so downstream logic knows when decoded data can be trusted.

---
 rtl/rx_word_align_ctrl.sv | 129 ++++++++++++
 tb/tb_rx_word_align_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_word_align_ctrl.sv
// rx_word_align_ctrl: comma-search word aligner with LOS/ACQ/SYNC link-sync state machine
module rx_word_align_ctrl #(
   parameter int COMMA_COUNT = 3,
   parameter int MAX_ERR     = 4,
   parameter int GOOD_RUN    = 4
) (
   input  logic       BitCLK_10,
   input  logic       Reset,
   input  logic [9:0] RxParallel_10,
   input  logic       EnAlign,
   output logic [9:0] RxAligned_10,
   output logic [3:0] AlignOffset,
   output logic       RxCommaDet,
   output logic       RxCodeErr,
   output logic       RxSync
);
   typedef enum logic [1:0] {LOS, ACQ, SYNC} state_t;
   state_t      state_q;
   logic [9:0]  prev_q;
   logic [9:0]  aligned_q;
   logic [3:0]  offset_q;
   logic        comma_det_q;
   logic        code_err_q;
   logic        sync_q;
   logic [2:0]  comma_cnt_q;
   logic [2:0]  err_cnt_q;
   logic [3:0]  run_cnt_q;
   logic [19:0] window;
   logic [19:0] shifted;
   logic [9:0]  comma_vec;
   logic [9:0]  lock_word;
   logic [3:0]  first_k;
   logic [3:0]  ones;
   logic        any_comma;
   logic        lock_comma;
   logic        mis_comma;
   logic        code_err;
   logic        bad_word;
   logic [2:0]  comma_cnt_inc;
   logic [2:0]  err_cnt_inc;
   logic [3:0]  run_cnt_inc;
   // Comma search over all ten offsets of the two-word window and decode of the locked word
   always_comb begin
      window = {prev_q, RxParallel_10};
      comma_vec = '0;
      for (int k = 0; k < 10; k++)
         comma_vec[k] = (window[19-k -: 7] == 7'b0011111) || (window[19-k -: 7] == 7'b1100000);
      first_k = 4'd0;
      for (int k = 9; k >= 0; k--)
         first_k = comma_vec[k] ? 4'(k) : first_k;
      any_comma = |comma_vec;
      shifted = window >> (5'd10 - {1'b0, offset_q});
      lock_word = shifted[9:0];
      lock_comma = comma_vec[offset_q];
      mis_comma = |(comma_vec & ~(10'd1 << offset_q));
      ones = 4'($countones(lock_word));
      code_err = (ones < 4'd4) || (ones > 4'd6);
      bad_word = code_err || mis_comma;
      comma_cnt_inc = comma_cnt_q + 3'd1;
      err_cnt_inc = err_cnt_q + 3'd1;
      run_cnt_inc = run_cnt_q + 4'd1;
   end
   // Sync state machine; the realigned word and its flags use the offset held before this edge
   always_ff @(posedge BitCLK_10) begin
      if (Reset) begin
         state_q     <= LOS;
         prev_q      <= '0;
         aligned_q   <= '0;
         offset_q    <= '0;
         comma_det_q <= 1'b0;
         code_err_q  <= 1'b0;
         sync_q      <= 1'b0;
         comma_cnt_q <= '0;
         err_cnt_q   <= '0;
         run_cnt_q   <= '0;
      end else begin
         prev_q      <= RxParallel_10;
         aligned_q   <= lock_word;
         comma_det_q <= lock_comma;
         code_err_q  <= code_err;
         case (state_q)
            LOS: begin
               if (EnAlign && any_comma) begin
                  offset_q    <= first_k;
                  comma_cnt_q <= 3'd1;
                  state_q     <= ACQ;
               end
            end
            ACQ: begin
               if (bad_word) begin
                  state_q <= LOS;
               end else if (lock_comma) begin
                  comma_cnt_q <= comma_cnt_inc;
                  if (comma_cnt_inc >= 3'(COMMA_COUNT)) begin
                     state_q   <= SYNC;
                     err_cnt_q <= '0;
                     run_cnt_q <= '0;
                     sync_q    <= 1'b1;
                  end
               end
            end
            SYNC: begin
               if (bad_word) begin
                  err_cnt_q <= err_cnt_inc;
                  run_cnt_q <= '0;
                  if (err_cnt_inc == 3'(MAX_ERR)) begin
                     state_q <= LOS;
                     sync_q  <= 1'b0;
                  end
               end else if (err_cnt_q != 3'd0 && run_cnt_inc == 4'(GOOD_RUN)) begin
                  err_cnt_q <= err_cnt_q - 3'd1;
                  run_cnt_q <= '0;
               end else begin
                  run_cnt_q <= (run_cnt_q == 4'(GOOD_RUN)) ? run_cnt_q : run_cnt_inc;
               end
            end
            default: begin
               state_q <= LOS;
               sync_q  <= 1'b0;
            end
         endcase
      end
   end
   assign RxAligned_10 = aligned_q;
   assign AlignOffset  = offset_q;
   assign RxCommaDet   = comma_det_q;
   assign RxCodeErr    = code_err_q;
   assign RxSync       = sync_q;
endmodule

// File: tb/tb_rx_word_align_ctrl.sv
// tb_rx_word_align_ctrl: directed stimulus with a per-cycle reference model of the aligner
module tb_rx_word_align_ctrl;
   localparam int COMMA_COUNT = 3;
   localparam int MAX_ERR     = 4;
   localparam int GOOD_RUN    = 4;
   localparam int LOS_S = 0, ACQ_S = 1, SYNC_S = 2;
   localparam logic [9:0] K = 10'h0FA;
   localparam logic [9:0] D = 10'h2AA;
   localparam logic [9:0] Z = 10'h000;
   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       EnAlign = 1'b0;
   logic [9:0] RxParallel_10 = '0;
   logic [9:0] RxAligned_10;
   logic [3:0] AlignOffset;
   logic       RxCommaDet;
   logic       RxCodeErr;
   logic       RxSync;
   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int m_state, m_off, m_cc, m_ec, m_rc;
   logic [9:0] m_prev, m_aligned;
   logic m_cd, m_ce, m_sync;
   bit txq[$];
   logic [9:0] seq_c [11] = '{Z, D, K, Z, D, K, Z, D, K, Z, D};
   logic [9:0] seq_d [13] = '{Z, D, K, D, K, D, Z, D, Z, D, Z, D, K};

   rx_word_align_ctrl #(.COMMA_COUNT(COMMA_COUNT), .MAX_ERR(MAX_ERR), .GOOD_RUN(GOOD_RUN)) dut (
      .BitCLK_10(clk),
      .Reset(Reset),
      .RxParallel_10(RxParallel_10),
      .EnAlign(EnAlign),
      .RxAligned_10(RxAligned_10),
      .AlignOffset(AlignOffset),
      .RxCommaDet(RxCommaDet),
      .RxCodeErr(RxCodeErr),
      .RxSync(RxSync)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] word_at(input logic [19:0] w, input int k);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) r[9-i] = w[19-k-i];
      return r;
   endfunction

   function automatic bit comma_at(input logic [19:0] w, input int k);
      logic [6:0] c;
      for (int i = 0; i < 7; i++) c[6-i] = w[19-k-i];
      return (c == 7'b0011111) || (c == 7'b1100000);
   endfunction

   function automatic int ones(input logic [9:0] w);
      int n = 0;
      for (int i = 0; i < 10; i++) n += int'(w[i]);
      return n;
   endfunction

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [19:0] win;
      logic [9:0] lw;
      int first;
      bit mis, lc, ce;
      win = {m_prev, RxParallel_10};
      first = -1;
      mis = 1'b0;
      for (int k = 9; k >= 0; k--) if (comma_at(win, k)) first = k;
      for (int k = 0; k < 10; k++) if (k != m_off && comma_at(win, k)) mis = 1'b1;
      lw = word_at(win, m_off);
      lc = comma_at(win, m_off);
      ce = (ones(lw) < 4) || (ones(lw) > 6);
      if (Reset) begin
         m_state = LOS_S; m_prev = '0; m_aligned = '0; m_off = 0;
         m_cd = 1'b0; m_ce = 1'b0; m_sync = 1'b0; m_cc = 0; m_ec = 0; m_rc = 0;
      end else begin
         m_aligned = lw; m_cd = lc; m_ce = ce; m_prev = RxParallel_10;
         if (m_state == LOS_S) begin
            if (EnAlign && first >= 0) begin m_off = first; m_cc = 1; m_state = ACQ_S; end
         end else if (m_state == ACQ_S) begin
            if (ce || mis) m_state = LOS_S;
            else if (lc) begin
               m_cc++;
               if (m_cc >= COMMA_COUNT) begin m_state = SYNC_S; m_ec = 0; m_rc = 0; end
            end
         end else begin
            if (ce || mis) begin
               m_ec++; m_rc = 0;
               if (m_ec == MAX_ERR) m_state = LOS_S;
            end else begin
               m_rc++;
               if (m_rc >= GOOD_RUN) begin
                  if (m_ec > 0) begin m_ec--; m_rc = 0; end
                  else m_rc = GOOD_RUN;
               end
            end
         end
         m_sync = (m_state == SYNC_S);
      end
   endtask

   task automatic step(input logic [9:0] w, input logic en, input logic rst);
      @(negedge clk);
      RxParallel_10 = w; EnAlign = en; Reset = rst;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic push_cg(input logic [9:0] c);
      for (int i = 9; i >= 0; i--) txq.push_back(c[i]);
   endtask

   task automatic ser(input int n);
      logic [9:0] w;
      repeat (n) begin
         w = '0;
         for (int i = 0; i < 10; i++) w = {w[8:0], txq.pop_front()};
         step(w, 1'b1, 1'b0);
      end
   endtask

   always @(negedge clk) if (chk_en) begin
      chk("aligned", RxAligned_10, m_aligned);
      chk("offset", 10'(AlignOffset), 10'(m_off));
      chk("comma_det", 10'(RxCommaDet), 10'(m_cd));
      chk("code_err", 10'(RxCodeErr), 10'(m_ce));
      chk("sync", 10'(RxSync), 10'(m_sync));
   end

   initial begin
      step(Z, 1'b0, 1'b1);
      step(Z, 1'b0, 1'b1);
      chk_en = 1'b1;
      chk("rst_sync", 10'(RxSync), 10'd0);
      chk("rst_offset", 10'(AlignOffset), 10'd0);
      chk("rst_aligned", RxAligned_10, 10'h000);
      txq.push_back(1'b0); txq.push_back(1'b1); txq.push_back(1'b0);
      repeat (10) begin push_cg(K); push_cg(D); end
      ser(2);
      chk("lock_offset3", 10'(AlignOffset), 10'd3);
      ser(1);
      chk("aligned_d215", RxAligned_10, 10'h2AA);
      ser(1);
      chk("aligned_k285", RxAligned_10, 10'h0FA);
      chk("comma_det_k285", 10'(RxCommaDet), 10'd1);
      ser(1);
      chk("sync_before_3rd", 10'(RxSync), 10'd0);
      ser(1);
      chk("sync_on_3rd", 10'(RxSync), 10'd1);
      chk("aligned_k285_b", RxAligned_10, 10'h0FA);
      ser(1);
      chk("aligned_d215_b", RxAligned_10, 10'h2AA);
      repeat (3) step(Z, 1'b1, 1'b0);
      chk("sync_errs_pending", 10'(RxSync), 10'd1);
      step(Z, 1'b1, 1'b1);
      chk("midrst_sync", 10'(RxSync), 10'd0);
      chk("midrst_offset", 10'(AlignOffset), 10'd0);
      chk("midrst_aligned", RxAligned_10, 10'h000);
      for (int i = 0; i < 6; i++) step((i % 2) ? D : K, 1'b0, 1'b0);
      chk("noalign_offset", 10'(AlignOffset), 10'd0);
      chk("noalign_sync", 10'(RxSync), 10'd0);
      for (int i = 6; i < 12; i++) begin
         step((i % 2) ? D : K, 1'b1, 1'b0);
         if (i == 10) chk("en_sync_before", 10'(RxSync), 10'd0);
      end
      chk("en_sync", 10'(RxSync), 10'd1);
      chk("en_offset0", 10'(AlignOffset), 10'd0);
      for (int j = 0; j < 11; j++) begin
         step(seq_c[j], 1'b1, 1'b0);
         if (j == 7) begin
            chk("three_err_sync", 10'(RxSync), 10'd1);
            chk("model_errcnt3", 10'(m_ec), 10'd3);
         end
         if (j == 9) chk("pre_fourth_sync", 10'(RxSync), 10'd1);
      end
      chk("fourth_err_drop", 10'(RxSync), 10'd0);
      for (int i = 0; i < 6; i++) step((i % 2) ? D : K, 1'b1, 1'b0);
      chk("resync", 10'(RxSync), 10'd1);
      for (int j = 0; j < 13; j++) begin
         step(seq_d[j], 1'b1, 1'b0);
         if (j == 5) chk("model_errcnt0", 10'(m_ec), 10'd0);
      end
      chk("goodrun_sync", 10'(RxSync), 10'd1);
      chk("model_errcnt3b", 10'(m_ec), 10'd3);
      step(Z, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step((i % 2) ? D : K, 1'b1, 1'b0);
      chk("acq_sync", 10'(RxSync), 10'd0);
      txq.delete();
      txq.push_back(1'b0);
      repeat (6) begin push_cg(K); push_cg(D); end
      ser(2);
      chk("mis_offset_held", 10'(AlignOffset), 10'd0);
      chk("mis_sync", 10'(RxSync), 10'd0);
      ser(2);
      chk("relock_offset1", 10'(AlignOffset), 10'd1);
      ser(1);
      chk("relock_aligned_d", RxAligned_10, 10'h2AA);
      ser(1);
      chk("relock_aligned_k", RxAligned_10, 10'h0FA);
      ser(1);
      chk("relock_sync_before", 10'(RxSync), 10'd0);
      ser(1);
      chk("relock_sync", 10'(RxSync), 10'd1);
      step(K, 1'b1, 1'b0);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
